// File: rtl/spart_rx_queue.sv
// SPART receive path: 2-flop RX synchroniser, 8N1 deserialiser and a show-ahead byte queue.
// Bytes land in the queue on the edge ending the stop-bit sample; a full queue drops arrivals unless popped that cycle.
module spart_rx_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  input  logic [15:0]   db,
  input  logic          rd_en,
  output logic [7:0]    rx_data,
  output logic          rx_q_empty,
  output logic          rx_q_full,
  output logic [CW-1:0] rx_count,
  output logic          overrun,
  output logic          framing_err,
  input  logic          clr_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [15:0]   cnt, cnt_nxt;
  logic [15:0]   db_q, db_q_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          push, stop_bad;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      db_q    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_m    <= RX;
      rx_s    <= rx_m;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      db_q    <= db_q_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    db_q_nxt    = db_q;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    push        = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        // Half-bit delay centres every later sample in its bit cell.
        if (!rx_s) begin
          cnt_nxt   = (db >> 1) - 16'd1;
          db_q_nxt  = db;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == 16'd0) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt     = db_q - 16'd1;
            bit_idx_nxt = 3'd0;
            state_nxt   = DATA;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          shreg_nxt   = {rx_s, shreg[7:1]};
          cnt_nxt     = db_q - 16'd1;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == 16'd0) begin
          push      = rx_s;
          stop_bad  = !rx_s;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_q_full  = (rx_count == CW'(DEPTH));
  assign rx_q_empty = (rx_count == '0);
  assign pop        = rd_en && !rx_q_empty;
  // A simultaneous pop frees a slot, so a full queue still accepts the byte.
  assign wr         = push && (!rx_q_full || pop);
  assign rx_data    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_count    <= '0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
      overrun     <= (push && rx_q_full && !pop) || (overrun && !clr_err);
      framing_err <= stop_bad || (framing_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_spart_rx_queue.sv
// Bench for spart_rx_queue: directed frames plus random frames checked against a byte-queue model.
module tb_spart_rx_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [15:0]   db = 16'd16;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_q_empty, rx_q_full, overrun, framing_err;
  logic [CW-1:0] rx_count;

  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] mq[$];
  logic m_ov = 1'b0;
  logic m_fe = 1'b0;

  spart_rx_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .db(db), .rd_en(rd_en),
    .rx_data(rx_data), .rx_q_empty(rx_q_empty), .rx_q_full(rx_q_full),
    .rx_count(rx_count), .overrun(overrun), .framing_err(framing_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_status(input string t);
    chk({t, ".count"}, 32'(rx_count), 32'(mq.size()));
    chk({t, ".empty"}, 32'(rx_q_empty), 32'(mq.size() == 0));
    chk({t, ".full"},  32'(rx_q_full),  32'(mq.size() == DEPTH));
    chk({t, ".ovr"},   32'(overrun),    32'(m_ov));
    chk({t, ".ferr"},  32'(framing_err), 32'(m_fe));
  endtask

  // Drives one 8N1 frame at d clocks per bit, then idles long enough for the push to land.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
    db = 16'(d);
    @(posedge clk); #1 rx = 1'b0;
    repeat (d) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (d) @(posedge clk);
    end
    #1 rx = stop;
    repeat (d) @(posedge clk);
    #1 rx = 1'b1;
    repeat (d / 2 + 4) @(posedge clk);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_fe = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else m_ov = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input int d);
    send_frame(b, stop, d);
    model_frame(b, stop);
  endtask

  task automatic pop_one(input string t);
    @(posedge clk); #1;
    if (mq.size() > 0) chk({t, ".data"}, 32'(rx_data), 32'(mq[0]));
    rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    m_ov = 1'b0;
    m_fe = 1'b0;
  endtask

  initial begin
    int lat;
    lat = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_status("reset");
    chk("reset.data", 32'(rx_data), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 1: single frame with exact latency from the first edge that samples RX low
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        @(posedge clk);
        for (int n = 1; n <= 400; n++) begin
          @(posedge clk); #1;
          if (!rx_q_empty) begin lat = n - 1; break; end
        end
      end
    join
    model_frame(8'hA5, 1'b1);
    chk("t1.latency", 32'(lat), 32'(2 + 8 + 9 * 16));
    chk_status("t1");
    pop_one("t1");
    chk_status("t1.after_pop");

    // 2: short glitch is a false start
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk_status("t2");

    // 3: overfill
    for (int i = 1; i <= 9; i++) begin
      frame(8'(i), 1'b1, 16);
      if (i == 8) chk_status("t3.full");
    end
    chk_status("t3.overrun");
    for (int i = 0; i < 8; i++) pop_one("t3");
    chk_status("t3.drained");
    clear_flags();

    // 4: pop in the very cycle a byte arrives at a full queue
    for (int i = 1; i <= 8; i++) frame(8'(i), 1'b1, 16);
    chk_status("t4.pre");
    fork
      send_frame(8'h55, 1'b1, 16);
      begin
        @(posedge clk);
        repeat (3 + 8 + 9 * 16 - 1) @(posedge clk);
        #1 chk("t4.head", 32'(rx_data), 32'h01);
        rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h55);
    chk_status("t4.post");
    for (int i = 0; i < 8; i++) pop_one("t4");
    chk_status("t4.drained");

    // 5: framing error, clear, then a clean frame
    frame(8'h3C, 1'b0, 16);
    chk_status("t5.ferr");
    clear_flags();
    chk_status("t5.clr");
    frame(8'h3C, 1'b1, 16);
    chk_status("t5.good");

    // 6: reset mid-frame with bytes queued and a flag set
    frame(8'h11, 1'b1, 16);
    frame(8'h22, 1'b1, 16);
    frame(8'h99, 1'b0, 16);
    chk_status("t6.pre");
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        @(posedge clk);
        repeat (16 * 4) @(posedge clk);
        #3 rst_n = 1'b0;
        mq.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
        #1 chk_status("t6.rst");
      end
    join
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    frame(8'hF0, 1'b1, 16);
    chk_status("t6.after");
    pop_one("t6");

    // Random frames, divisors, pops and clears
    for (int k = 0; k < 30; k++) begin
      frame(8'($urandom), $urandom_range(0, 9) != 0, $urandom_range(4, 24));
      chk_status("rnd");
      for (int p = $urandom_range(0, 2); p > 0; p--) pop_one("rnd");
      if ($urandom_range(0, 4) == 0) clear_flags();
    end
    while (mq.size() > 0) pop_one("rnd.drain");
    pop_one("rnd.empty_pop");
    chk_status("rnd.end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end
endmodule
